multi_channel_data_sync: RTL and testbench



---
 rtl/multi_channel_data_sync_pkg.sv | 23 ++
 rtl/multi_channel_data_sync_channel.sv | 106 ++++++++++
 rtl/multi_channel_data_sync.sv | 49 ++++
 tb/tb_multi_channel_data_sync.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_channel_data_sync_pkg.sv
// Shared encodings and parameter limits for the multi-channel enable-qualified bus synchronizer.
package multi_channel_data_sync_pkg;

  localparam int unsigned MODE_LEVEL  = 0;
  localparam int unsigned MODE_TOGGLE = 1;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  localparam int unsigned NUM_STAGES_MIN = 2;
  localparam int unsigned NUM_STAGES_MAX = 8;
  localparam int unsigned NUM_CH_MIN     = 1;
  localparam int unsigned NUM_CH_MAX     = 8;

  function automatic logic num_stages_legal(int unsigned n);
    return (n >= NUM_STAGES_MIN) && (n <= NUM_STAGES_MAX);
  endfunction

  function automatic logic num_ch_legal(int unsigned n);
    return (n >= NUM_CH_MIN) && (n <= NUM_CH_MAX);
  endfunction

endpackage

// File: rtl/multi_channel_data_sync_channel.sv
// One channel: enable synchronizer chain, edge detect, capture/hold FSM, ack toggle and sticky overrun.
module multi_channel_data_sync_channel
  import multi_channel_data_sync_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = 3,
  parameter int unsigned BUS_WIDTH   = 8,
  parameter int unsigned TOGGLE_MODE = MODE_LEVEL
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] unsync_bus,
  input  logic                 bus_enable,
  input  logic                 sync_ready,
  input  logic                 overrun_clr,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 sync_valid,
  output logic                 enable_pulse,
  output logic                 ack_toggle,
  output logic                 overrun
);

  logic [NUM_STAGES-1:0] sync_q;
  logic [0:0]            state_q;
  logic [0:0]            state_d;
  logic [BUS_WIDTH-1:0]  bus_d;
  logic                  valid_d;
  logic                  pulse_d;
  logic                  ack_d;
  logic                  ovr_d;
  logic                  evt_c;

  // Enable enters at the top stage and shifts toward stage 0 (oldest).
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {bus_enable, sync_q[NUM_STAGES-1:1]};
    end
  end

  always_comb begin
    if (TOGGLE_MODE == MODE_TOGGLE) begin
      evt_c = sync_q[1] ^ sync_q[0];
    end else begin
      evt_c = sync_q[1] & ~sync_q[0];
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      sync_bus     <= '0;
      sync_valid   <= 1'b0;
      enable_pulse <= 1'b0;
      ack_toggle   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_bus     <= bus_d;
      sync_valid   <= valid_d;
      enable_pulse <= pulse_d;
      ack_toggle   <= ack_d;
      overrun      <= ovr_d;
    end
  end

  // Next state; a held word is never overwritten unless it is accepted in the same cycle.
  always_comb begin
    state_d = state_q;
    bus_d   = sync_bus;
    valid_d = sync_valid;
    pulse_d = 1'b0;
    ack_d   = ack_toggle;
    ovr_d   = overrun & ~overrun_clr;
    case (state_q)
      ST_EMPTY: begin
        if (evt_c) begin
          state_d = ST_FULL;
          bus_d   = unsync_bus;
          valid_d = 1'b1;
          pulse_d = 1'b1;
        end
      end
      ST_FULL: begin
        if (sync_ready) begin
          ack_d = ~ack_toggle;
          if (evt_c) begin
            bus_d   = unsync_bus;
            pulse_d = 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = ST_EMPTY;
          end
        end else if (evt_c) begin
          ovr_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multi_channel_data_sync.sv
// Top: NUM_CH independent enable-qualified bus synchronizers in the destination clock domain.
module multi_channel_data_sync
  import multi_channel_data_sync_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = 3,
  parameter int unsigned BUS_WIDTH   = 8,
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned TOGGLE_MODE = MODE_LEVEL
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus,
  input  logic [NUM_CH-1:0]           bus_enable,
  input  logic [NUM_CH-1:0]           sync_ready,
  output logic [NUM_CH*BUS_WIDTH-1:0] sync_bus,
  output logic [NUM_CH-1:0]           sync_valid,
  output logic [NUM_CH-1:0]           enable_pulse,
  output logic [NUM_CH-1:0]           ack_toggle,
  output logic [NUM_CH-1:0]           overrun,
  input  logic [NUM_CH-1:0]           overrun_clr
);

  generate
    if (!num_stages_legal(NUM_STAGES) || !num_ch_legal(NUM_CH)) begin : g_bad_param
      $error("multi_channel_data_sync: NUM_STAGES must be 2..8 and NUM_CH 1..8");
    end
  endgenerate

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    multi_channel_data_sync_channel #(
      .NUM_STAGES  (NUM_STAGES),
      .BUS_WIDTH   (BUS_WIDTH),
      .TOGGLE_MODE (TOGGLE_MODE)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .unsync_bus   (unsync_bus[c*BUS_WIDTH +: BUS_WIDTH]),
      .bus_enable   (bus_enable[c]),
      .sync_ready   (sync_ready[c]),
      .overrun_clr  (overrun_clr[c]),
      .sync_bus     (sync_bus[c*BUS_WIDTH +: BUS_WIDTH]),
      .sync_valid   (sync_valid[c]),
      .enable_pulse (enable_pulse[c]),
      .ack_toggle   (ack_toggle[c]),
      .overrun      (overrun[c])
    );
  end

endmodule

// File: tb/tb_multi_channel_data_sync.sv
// Bench: a level-mode 4-channel and a toggle-mode 2-channel instance checked against a delay-line/transaction model.
module tb_multi_channel_data_sync;

  localparam int unsigned NS = 3;
  localparam int unsigned BW = 8;
  localparam int unsigned NL = 4;
  localparam int unsigned NT = 2;
  localparam int unsigned NG = NL + NT;

  logic clk = 1'b0;
  logic rst;
  logic [NG-1:0] en, rdy, clr;
  logic [BW-1:0] bus [NG];

  logic [NL*BW-1:0] sb_l;
  logic [NT*BW-1:0] sb_t;
  logic [NL-1:0]    sv_l, ep_l, ak_l, ov_l;
  logic [NT-1:0]    sv_t, ep_t, ak_t, ov_t;
  logic [NG*BW-1:0] sb_all;
  logic [NG-1:0]    sv_all, ep_all, ak_all, ov_all;

  assign sb_all = {sb_t, sb_l};
  assign sv_all = {sv_t, sv_l};
  assign ep_all = {ep_t, ep_l};
  assign ak_all = {ak_t, ak_l};
  assign ov_all = {ov_t, ov_l};

  int checks = 0;
  int failures = 0;
  int fail_prints = 0;

  always #5 clk = ~clk;

  multi_channel_data_sync #(
    .NUM_STAGES(NS), .BUS_WIDTH(BW), .NUM_CH(NL), .TOGGLE_MODE(0)
  ) u_dut_l (
    .clk          (clk),
    .rst          (rst),
    .unsync_bus   ({bus[3], bus[2], bus[1], bus[0]}),
    .bus_enable   (en[3:0]),
    .sync_ready   (rdy[3:0]),
    .sync_bus     (sb_l),
    .sync_valid   (sv_l),
    .enable_pulse (ep_l),
    .ack_toggle   (ak_l),
    .overrun      (ov_l),
    .overrun_clr  (clr[3:0])
  );

  multi_channel_data_sync #(
    .NUM_STAGES(NS), .BUS_WIDTH(BW), .NUM_CH(NT), .TOGGLE_MODE(1)
  ) u_dut_t (
    .clk          (clk),
    .rst          (rst),
    .unsync_bus   ({bus[5], bus[4]}),
    .bus_enable   (en[5:4]),
    .sync_ready   (rdy[5:4]),
    .sync_bus     (sb_t),
    .sync_valid   (sv_t),
    .enable_pulse (ep_t),
    .ack_toggle   (ak_t),
    .overrun      (ov_t),
    .overrun_clr  (clr[5:4])
  );

  // Model: enable history as a delay line, plus the per-channel word-holding rules.
  bit            hist [NG][$];
  logic [BW-1:0] m_bus [NG];
  logic          m_valid [NG];
  logic          m_pulse [NG];
  logic          m_ack [NG];
  logic          m_ovr [NG];

  always @(posedge clk) begin : model
    bit newer, older, ev, ovr_set;
    for (int g = 0; g < NG; g++) begin
      if (rst) begin
        hist[g].delete();
        for (int i = 0; i < NS; i++) hist[g].push_back(1'b0);
        m_bus[g] = '0; m_valid[g] = 1'b0; m_pulse[g] = 1'b0;
        m_ack[g] = 1'b0; m_ovr[g] = 1'b0;
      end else begin
        // hist[g][i] is the enable sampled i+1 edges ago
        newer = hist[g][NS-2];
        older = hist[g][NS-1];
        ev = (g >= NL) ? (newer ^ older) : (newer & ~older);
        hist[g].push_front(en[g]);
        void'(hist[g].pop_back());
        ovr_set = m_valid[g] && !rdy[g] && ev;
        if (clr[g]) m_ovr[g] = 1'b0;
        if (ovr_set) m_ovr[g] = 1'b1;
        m_pulse[g] = 1'b0;
        if (!m_valid[g]) begin
          if (ev) begin
            m_bus[g] = bus[g]; m_valid[g] = 1'b1; m_pulse[g] = 1'b1;
          end
        end else if (rdy[g]) begin
          m_ack[g] = ~m_ack[g];
          if (ev) begin
            m_bus[g] = bus[g]; m_pulse[g] = 1'b1;
          end else begin
            m_valid[g] = 1'b0;
          end
        end
      end
    end
  end

  task automatic report(input string name, input int g, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (fail_prints < 40) begin
        fail_prints++;
        $display("FAIL %s ch%0d t=%0t got=%0h expected=%0h", name, g, $time, got, exp);
      end
    end
  endtask

  task automatic lit(input string name, input logic [63:0] got, input logic [63:0] exp);
    report(name, -1, got, exp);
  endtask

  // Model comparison on every falling edge.
  always @(negedge clk) begin
    for (int g = 0; g < NG; g++) begin
      report("sync_bus", g, 64'(sb_all[g*BW +: BW]), 64'(m_bus[g]));
      report("sync_valid", g, 64'(sv_all[g]), 64'(m_valid[g]));
      report("enable_pulse", g, 64'(ep_all[g]), 64'(m_pulse[g]));
      report("ack_toggle", g, 64'(ak_all[g]), 64'(m_ack[g]));
      report("overrun", g, 64'(ov_all[g]), 64'(m_ovr[g]));
    end
  end

  initial begin
    rst = 1'b1; en = '0; rdy = '0; clr = '0;
    for (int g = 0; g < NG; g++) bus[g] = '0;
    repeat (2) @(negedge clk);
    lit("rst_valid", 64'(sv_all), 64'h0);
    lit("rst_pulse", 64'(ep_all), 64'h0);
    lit("rst_ack", 64'(ak_all), 64'h0);
    lit("rst_ovr", 64'(ov_all), 64'h0);
    lit("rst_bus", 64'(sb_all), 64'h0);
    rst = 1'b0;

    // Level capture of 0xA5 on ch0: visible after edge k+2
    bus[0] = 8'hA5; en[0] = 1'b1;
    @(negedge clk); lit("t1_valid_k", 64'(sv_all[0]), 64'h0);
    @(negedge clk); lit("t1_valid_k1", 64'(sv_all[0]), 64'h0);
    @(negedge clk);
    lit("t1_bus", 64'(sb_all[7:0]), 64'hA5);
    lit("t1_valid", 64'(sv_all[0]), 64'h1);
    lit("t1_pulse", 64'(ep_all[0]), 64'h1);
    en[0] = 1'b0;
    @(negedge clk);
    lit("t1_pulse_once", 64'(ep_all[0]), 64'h0);
    lit("t1_hold", 64'(sv_all[0]), 64'h1);
    rdy[0] = 1'b1;
    @(negedge clk);
    lit("t1_consumed", 64'(sv_all[0]), 64'h0);
    lit("t1_ack", 64'(ak_all[0]), 64'h1);
    rdy[0] = 1'b0;

    // Toggle mode on ch5: 0->1 with 0x3C, 1->0 with 0xC3
    bus[5] = 8'h3C; en[5] = 1'b1;
    repeat (3) @(negedge clk);
    lit("t2_bus_a", 64'(sb_all[47:40]), 64'h3C);
    lit("t2_pulse_a", 64'(ep_all[5]), 64'h1);
    rdy[5] = 1'b1;
    @(negedge clk);
    lit("t2_ack_a", 64'(ak_all[5]), 64'h1);
    rdy[5] = 1'b0; bus[5] = 8'hC3; en[5] = 1'b0;
    repeat (3) @(negedge clk);
    lit("t2_bus_b", 64'(sb_all[47:40]), 64'hC3);
    lit("t2_pulse_b", 64'(ep_all[5]), 64'h1);
    rdy[5] = 1'b1;
    @(negedge clk);
    lit("t2_ack_b", 64'(ak_all[5]), 64'h0);
    lit("t2_empty", 64'(sv_all[5]), 64'h0);
    rdy[5] = 1'b0;

    // Overrun: second event while ch0 holds 0x11
    bus[0] = 8'h11; en[0] = 1'b1;
    repeat (3) @(negedge clk);
    lit("t3_first", 64'(sb_all[7:0]), 64'h11);
    en[0] = 1'b0;
    @(negedge clk);
    bus[0] = 8'h22; en[0] = 1'b1;
    repeat (3) @(negedge clk);
    lit("t3_kept", 64'(sb_all[7:0]), 64'h11);
    lit("t3_ovr", 64'(ov_all[0]), 64'h1);
    lit("t3_no_pulse", 64'(ep_all[0]), 64'h0);
    en[0] = 1'b0; clr[0] = 1'b1;
    @(negedge clk);
    lit("t3_ovr_clr", 64'(ov_all[0]), 64'h0);
    clr[0] = 1'b0;

    // Event coinciding with sync_ready: accept 0x11, capture 0x22
    bus[0] = 8'h22; en[0] = 1'b1;
    repeat (2) @(negedge clk);
    rdy[0] = 1'b1;
    @(negedge clk);
    lit("t4_bus", 64'(sb_all[7:0]), 64'h22);
    lit("t4_valid", 64'(sv_all[0]), 64'h1);
    lit("t4_pulse", 64'(ep_all[0]), 64'h1);
    lit("t4_ack", 64'(ak_all[0]), 64'h0);
    lit("t4_no_ovr", 64'(ov_all[0]), 64'h0);
    rdy[0] = 1'b0; en[0] = 1'b0;
    @(negedge clk);
    rdy[0] = 1'b1;
    @(negedge clk);
    lit("t4_drain", 64'(sv_all[0]), 64'h0);
    rdy[0] = 1'b0;

    // Reset while ch0 is full and ch5's chain is mid-shift
    bus[0] = 8'h55; en[0] = 1'b1;
    repeat (3) @(negedge clk);
    en[0] = 1'b0; en[5] = 1'b1;
    @(negedge clk);
    rst = 1'b1; en[5] = 1'b0;
    @(negedge clk);
    lit("t5_valid", 64'(sv_all), 64'h0);
    lit("t5_ack", 64'(ak_all), 64'h0);
    lit("t5_bus", 64'(sb_all), 64'h0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      lit("t5_quiet", 64'({sv_all, ep_all}), 64'h0);
    end

    // Simultaneous events on all level channels
    for (int g = 0; g < NL; g++) begin
      bus[g] = BW'(g + 1); en[g] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < NL; g++) begin
      report("t6_bus", g, 64'(sb_all[g*BW +: BW]), 64'(g + 1));
      report("t6_pulse", g, 64'(ep_all[g]), 64'h1);
    end
    en[3:0] = '0; rdy[3:0] = 4'hF;
    @(negedge clk);
    lit("t6_drain", 64'(sv_all[3:0]), 64'h0);
    rdy[3:0] = '0;

    // Randomized traffic, including occasional resets
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      for (int g = 0; g < NG; g++) begin
        if ($urandom_range(0, 3) == 0) en[g] = ~en[g];
        rdy[g] = ($urandom_range(0, 2) == 0);
        clr[g] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 1) == 0) bus[g] = BW'($urandom);
      end
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
